// File: rtl/timing_ctrl_gen_pkg.sv
// Shared constants and sizing helper for the timing/control generator.
package timing_ctrl_gen_pkg;

    localparam int SC_W_DEF = 4;
    localparam int OP_W_DEF = 3;

    // Width of a one-hot bus that decodes a w-bit value.
    function automatic int pow2(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational W-to-2**W one-hot decoder.
module dec_onehot
    import timing_ctrl_gen_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]       sel,
    output logic [pow2(W)-1:0] onehot
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/timing_ctrl_gen.sv
// Sequence counter with one-hot timing outputs, wrap pulse and latched opcode/indirect decode.
module timing_ctrl_gen
    import timing_ctrl_gen_pkg::*;
#(
    parameter int SC_W = SC_W_DEF,
    parameter int OP_W = OP_W_DEF,
    parameter int TERM = (1 << SC_W) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sc_inc,
    input  logic                  sc_clr,
    input  logic                  ir_load,
    input  logic [OP_W-1:0]       ir_op,
    input  logic                  ir_i,
    output logic [SC_W-1:0]       sc,
    output logic [pow2(SC_W)-1:0] t,
    output logic [pow2(OP_W)-1:0] d,
    output logic                  i_flag,
    output logic                  wrap
);

    if (TERM >= (1 << SC_W) || TERM == 0) begin : g_bad_term
        $error("timing_ctrl_gen: TERM must be in 1 .. 2**SC_W-1");
    end

    localparam logic [SC_W-1:0] TERM_SC = SC_W'(TERM);

    logic [SC_W-1:0]       sc_next;
    logic                  wrap_next;
    logic [OP_W-1:0]       op_q;
    logic                  i_q;
    logic                  ir_valid;
    logic [pow2(OP_W)-1:0] d_raw;

    // Clear beats increment; only a plain increment at TERM produces a wrap.
    always_comb begin
        sc_next   = sc;
        wrap_next = 1'b0;
        if (sc_clr) begin
            sc_next = '0;
        end else if (sc_inc) begin
            if (sc == TERM_SC) begin
                sc_next   = '0;
                wrap_next = 1'b1;
            end else begin
                sc_next = sc + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            sc       <= '0;
            wrap     <= 1'b0;
            op_q     <= '0;
            i_q      <= 1'b0;
            ir_valid <= 1'b0;
        end else begin
            sc   <= sc_next;
            wrap <= wrap_next;
            if (ir_load) begin
                op_q     <= ir_op;
                i_q      <= ir_i;
                ir_valid <= 1'b1;
            end
        end
    end

    dec_onehot #(.W(SC_W)) u_dec_t (
        .sel    (sc),
        .onehot (t)
    );

    dec_onehot #(.W(OP_W)) u_dec_d (
        .sel    (op_q),
        .onehot (d_raw)
    );

    assign d      = ir_valid ? d_raw : '0;
    assign i_flag = ir_valid & i_q;

endmodule
